// File: rtl/psx_wb_pkg.sv
// rtl/psx_wb_pkg.sv - shared Wishbone B4 burst constants and burst-master state encoding
package psx_wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } wbm_state_t;

endpackage

// File: rtl/wb_master_skid.sv
// rtl/wb_master_skid.sv - one-word write-data holding register for the burst master
// Ports: i_clk/i_rst clock and async active-high reset; i_clr drops any held word;
//        i_load captures i_data; i_free releases the word; o_full/o_data hold state.
module wb_master_skid (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clr,
    input  logic        i_load,
    input  logic [31:0] i_data,
    input  logic        i_free,
    output logic        o_full,
    output logic [31:0] o_data
);

    logic        r_full;
    logic [31:0] r_data;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else begin
            if (i_load) begin
                r_data <= i_data;
            end
            // A load in the same cycle as a free is a refill, so it keeps the register full.
            if (i_clr) begin
                r_full <= 1'b0;
            end else if (i_load) begin
                r_full <= 1'b1;
            end else if (i_free) begin
                r_full <= 1'b0;
            end
        end
    end

    assign o_full = r_full;
    assign o_data = r_data;

endmodule

// File: rtl/wb_burst_master.sv
// rtl/wb_burst_master.sv - pipelined Wishbone B4 incrementing-burst master
// Ports: CLK/RST_ASYNC; CMD_* command handshake (address, we, sel, len-1);
//        WR_* write-data stream in; RD_* read-data stream out; DONE_OUT/ERR_OUT completion;
//        WB_* pipelined Wishbone master bus.
// Optional: WB_BURST_MASTER_TIMEOUT_EN adds an ack watchdog of TIMEOUT_CYC cycles.
module wb_burst_master
    import psx_wb_pkg::*;
#(
    parameter int MAX_LEN_P2  = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                  CLK,
    input  logic                  RST_ASYNC,
    input  logic                  CMD_VALID_IN,
    output logic                  CMD_READY_OUT,
    input  logic [31:0]           CMD_ADR_IN,
    input  logic                  CMD_WE_IN,
    input  logic [3:0]            CMD_SEL_IN,
    input  logic [MAX_LEN_P2-1:0] CMD_LEN_IN,
    input  logic [31:0]           WR_DAT_IN,
    input  logic                  WR_VALID_IN,
    output logic                  WR_READY_OUT,
    output logic [31:0]           RD_DAT_OUT,
    output logic                  RD_VALID_OUT,
    output logic                  DONE_OUT,
    output logic                  ERR_OUT,
    output logic [31:0]           WB_ADR_OUT,
    output logic                  WB_CYC_OUT,
    output logic                  WB_STB_OUT,
    output logic                  WB_WE_OUT,
    output logic [3:0]            WB_SEL_OUT,
    output logic [2:0]            WB_CTI_OUT,
    output logic [1:0]            WB_BTE_OUT,
    output logic [31:0]           WB_DAT_WR_OUT,
    input  logic                  WB_ACK_IN,
    input  logic                  WB_STALL_IN,
    input  logic                  WB_ERR_IN,
    input  logic [31:0]           WB_DAT_RD_IN
);

    localparam int LP_CNT_W = MAX_LEN_P2 + 1;

    wbm_state_t            r_state;
    wbm_state_t            w_state_nxt;
    logic [31:0]           r_adr;
    logic                  r_we;
    logic [3:0]            r_sel;
    logic [MAX_LEN_P2-1:0] r_len;
    logic [LP_CNT_W-1:0]   r_stb_cnt;
    logic [LP_CNT_W-1:0]   r_ack_cnt;
    logic                  r_err;
    logic                  r_rd_valid;
    logic [31:0]           r_rd_dat;

    logic                  w_busy;
    logic                  w_cmd_acc;
    logic                  w_last;
    logic                  w_stb;
    logic                  w_stb_acc;
    logic                  w_ack;
    logic                  w_abort;
    logic                  w_timeout;
    logic                  w_wr_ready;
    logic                  w_skid_full;
    logic [31:0]           w_skid_dat;
    logic [LP_CNT_W-1:0]   w_ack_cnt_nxt;
    logic [LP_CNT_W-1:0]   w_len_beats;

    assign w_busy        = (r_state == ST_ISSUE) || (r_state == ST_DRAIN);
    assign w_cmd_acc     = CMD_VALID_IN && CMD_READY_OUT;
    assign w_last        = (r_stb_cnt == {1'b0, r_len});
    assign w_stb         = (r_state == ST_ISSUE) && (!r_we || w_skid_full);
    assign w_stb_acc     = w_stb && !WB_STALL_IN;
    assign w_ack         = w_busy && WB_ACK_IN;
    assign w_ack_cnt_nxt = r_ack_cnt + {{MAX_LEN_P2{1'b0}}, w_ack};
    assign w_len_beats   = {1'b0, r_len} + LP_CNT_W'(1);
    assign w_abort       = w_busy && (WB_ERR_IN || w_timeout);
    // Refill is offered while the held word leaves, but never beyond the final beat.
    assign w_wr_ready    = (r_state == ST_ISSUE) && r_we &&
                           (!w_skid_full || (w_stb_acc && !w_last));

`ifdef WB_BURST_MASTER_TIMEOUT_EN
    localparam int LP_WDOG_W = $clog2(TIMEOUT_CYC + 1);
    logic [LP_WDOG_W-1:0] r_wdog;

    always_ff @(posedge CLK or posedge RST_ASYNC) begin
        if (RST_ASYNC) begin
            r_wdog <= '0;
        end else if (!w_busy || w_ack) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + LP_WDOG_W'(1);
        end
    end

    // Fires on the TIMEOUT_CYC-th consecutive busy cycle without an ack.
    assign w_timeout = w_busy && !w_ack && (r_wdog == LP_WDOG_W'(TIMEOUT_CYC - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_cmd_acc) w_state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                if (w_abort) begin
                    w_state_nxt = ST_DONE;
                end else if (w_stb_acc && w_last) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_abort || (w_ack_cnt_nxt == w_len_beats)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST_ASYNC) begin
        if (RST_ASYNC) begin
            r_state    <= ST_IDLE;
            r_adr      <= '0;
            r_we       <= 1'b0;
            r_sel      <= '0;
            r_len      <= '0;
            r_stb_cnt  <= '0;
            r_ack_cnt  <= '0;
            r_err      <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_dat   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rd_valid <= w_ack && !r_we;
            if (w_ack && !r_we) begin
                r_rd_dat <= WB_DAT_RD_IN;
            end
            if (w_cmd_acc) begin
                r_adr     <= CMD_ADR_IN;
                r_we      <= CMD_WE_IN;
                r_sel     <= CMD_SEL_IN;
                r_len     <= CMD_LEN_IN;
                r_stb_cnt <= '0;
                r_ack_cnt <= '0;
                r_err     <= 1'b0;
            end else begin
                if (w_stb_acc) begin
                    r_adr     <= r_adr + 32'd4;
                    r_stb_cnt <= r_stb_cnt + LP_CNT_W'(1);
                end
                if (w_ack) begin
                    r_ack_cnt <= w_ack_cnt_nxt;
                end
                if (w_abort) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    wb_master_skid u_skid (
        .i_clk  (CLK),
        .i_rst  (RST_ASYNC),
        .i_clr  (r_state == ST_DONE),
        .i_load (WR_VALID_IN && w_wr_ready),
        .i_data (WR_DAT_IN),
        .i_free (w_stb_acc),
        .o_full (w_skid_full),
        .o_data (w_skid_dat)
    );

    // Gated with reset so the handshake stays closed for as long as reset is held.
    assign CMD_READY_OUT = (r_state == ST_IDLE) && !RST_ASYNC;
    assign WR_READY_OUT  = w_wr_ready;
    assign RD_VALID_OUT  = r_rd_valid;
    assign RD_DAT_OUT    = r_rd_dat;
    assign DONE_OUT      = (r_state == ST_DONE);
    assign ERR_OUT       = (r_state == ST_DONE) && r_err;
    assign WB_CYC_OUT    = w_busy;
    assign WB_STB_OUT    = w_stb;
    assign WB_WE_OUT     = w_busy && r_we;
    assign WB_ADR_OUT    = r_adr;
    assign WB_SEL_OUT    = r_sel;
    assign WB_CTI_OUT    = !w_busy ? CTI_CLASSIC : (w_last ? CTI_EOB : CTI_INCR);
    assign WB_BTE_OUT    = BTE_LINEAR;
    assign WB_DAT_WR_OUT = w_skid_dat;

endmodule

// File: tb/tb_wb_burst_master.sv
// tb/tb_wb_burst_master.sv - self-checking bench for wb_burst_master
module tb_wb_burst_master;
    import psx_wb_pkg::*;

    localparam int LEN_W = 4;

    logic             CLK = 1'b0;
    logic             RST_ASYNC;
    logic             CMD_VALID_IN;
    logic             CMD_READY_OUT;
    logic [31:0]      CMD_ADR_IN;
    logic             CMD_WE_IN;
    logic [3:0]       CMD_SEL_IN;
    logic [LEN_W-1:0] CMD_LEN_IN;
    logic [31:0]      WR_DAT_IN;
    logic             WR_VALID_IN;
    logic             WR_READY_OUT;
    logic [31:0]      RD_DAT_OUT;
    logic             RD_VALID_OUT;
    logic             DONE_OUT;
    logic             ERR_OUT;
    logic [31:0]      WB_ADR_OUT;
    logic             WB_CYC_OUT;
    logic             WB_STB_OUT;
    logic             WB_WE_OUT;
    logic [3:0]       WB_SEL_OUT;
    logic [2:0]       WB_CTI_OUT;
    logic [1:0]       WB_BTE_OUT;
    logic [31:0]      WB_DAT_WR_OUT;
    logic             WB_ACK_IN;
    logic             WB_STALL_IN;
    logic             WB_ERR_IN;
    logic [31:0]      WB_DAT_RD_IN;

    always #5 CLK = ~CLK;

    wb_burst_master #(.MAX_LEN_P2(LEN_W), .TIMEOUT_CYC(16)) dut (
        .CLK(CLK), .RST_ASYNC(RST_ASYNC),
        .CMD_VALID_IN(CMD_VALID_IN), .CMD_READY_OUT(CMD_READY_OUT),
        .CMD_ADR_IN(CMD_ADR_IN), .CMD_WE_IN(CMD_WE_IN), .CMD_SEL_IN(CMD_SEL_IN),
        .CMD_LEN_IN(CMD_LEN_IN),
        .WR_DAT_IN(WR_DAT_IN), .WR_VALID_IN(WR_VALID_IN), .WR_READY_OUT(WR_READY_OUT),
        .RD_DAT_OUT(RD_DAT_OUT), .RD_VALID_OUT(RD_VALID_OUT),
        .DONE_OUT(DONE_OUT), .ERR_OUT(ERR_OUT),
        .WB_ADR_OUT(WB_ADR_OUT), .WB_CYC_OUT(WB_CYC_OUT), .WB_STB_OUT(WB_STB_OUT),
        .WB_WE_OUT(WB_WE_OUT), .WB_SEL_OUT(WB_SEL_OUT), .WB_CTI_OUT(WB_CTI_OUT),
        .WB_BTE_OUT(WB_BTE_OUT), .WB_DAT_WR_OUT(WB_DAT_WR_OUT),
        .WB_ACK_IN(WB_ACK_IN), .WB_STALL_IN(WB_STALL_IN), .WB_ERR_IN(WB_ERR_IN),
        .WB_DAT_RD_IN(WB_DAT_RD_IN)
    );

    typedef struct {
        bit          we;
        logic [31:0] adr;
        int          len;
        logic [3:0]  sel;
        int          stall_pct;
        int          max_lat;
        bit          gap;
        int          err_beat;
        bit          exp_err;
        int          exp_beats;
    } vec_t;

    typedef struct {
        int          rdy;
        int          beat;
        logic [31:0] a;
    } pend_t;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_pat(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    function automatic logic [31:0] wr_pat(input int idx, input int beat);
        return 32'hD000_0000 | 32'(idx << 8) | 32'(beat);
    endfunction

    task automatic idle_inputs();
        CMD_VALID_IN = 1'b0;
        WR_VALID_IN  = 1'b0;
        WB_ACK_IN    = 1'b0;
        WB_ERR_IN    = 1'b0;
        WB_STALL_IN  = 1'b0;
        WB_DAT_RD_IN = '0;
    endtask

    // Presents a command at a falling edge, checks it is accepted, and returns at
    // the falling edge of the first cycle after acceptance.
    task automatic issue_cmd(input bit we, input logic [31:0] adr, input int len,
                             input logic [3:0] sel, input string tag);
        @(negedge CLK);
        CMD_VALID_IN = 1'b1;
        CMD_WE_IN    = we;
        CMD_ADR_IN   = adr;
        CMD_SEL_IN   = sel;
        CMD_LEN_IN   = LEN_W'(len);
        #1;
        chk({tag, "_cmd_ready"}, 32'(CMD_READY_OUT), 32'd1);
        @(negedge CLK);
        CMD_VALID_IN = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        pend_t       q[$];
        pend_t       p;
        int          n, acc, sent, rd_cnt, done_cnt, last_ack_n, done_n;
        bit          err_seen, aborted, drv_ack, drv_err;
        logic [31:0] exp_adr;
        string       tag;
        tag = $sformatf("v%0d", idx);
        issue_cmd(v.we, v.adr, v.len, v.sel, tag);
        n = 1; acc = 0; sent = 0; rd_cnt = 0; done_cnt = 0;
        last_ack_n = -1; done_n = -1; err_seen = 1'b0; aborted = 1'b0;
        while (done_cnt == 0 && n < 600) begin
            drv_ack = 1'b0;
            drv_err = 1'b0;
            WB_ACK_IN    = 1'b0;
            WB_ERR_IN    = 1'b0;
            WB_DAT_RD_IN = '0;
            if (!aborted && q.size() > 0 && q[0].rdy <= n) begin
                if (q[0].beat == v.err_beat) begin
                    WB_ERR_IN = 1'b1;
                    drv_err   = 1'b1;
                end else begin
                    WB_ACK_IN    = 1'b1;
                    WB_DAT_RD_IN = v.we ? 32'h0 : rd_pat(q[0].a);
                    drv_ack      = 1'b1;
                end
            end
            WB_STALL_IN = (v.stall_pct > 0) && (int'($urandom_range(99, 0)) < v.stall_pct);
            WR_VALID_IN = v.we && (sent <= v.len) && (!v.gap || (n % 2 == 1));
            WR_DAT_IN   = wr_pat(idx, sent);
            #1;
            if (RD_VALID_OUT) begin
                chk({tag, "_rd_dat"}, RD_DAT_OUT, rd_pat(v.adr + 32'(4 * rd_cnt)));
                rd_cnt++;
            end
            if (DONE_OUT) begin
                done_cnt++;
                done_n   = n;
                err_seen = ERR_OUT;
                chk({tag, "_cyc_in_done"}, 32'(WB_CYC_OUT), 32'd0);
            end
            if (WB_STB_OUT) begin
                exp_adr = v.adr + 32'(4 * acc);
                chk({tag, "_adr"}, WB_ADR_OUT, exp_adr);
                chk({tag, "_cti"}, 32'(WB_CTI_OUT), 32'((acc == v.len) ? CTI_EOB : CTI_INCR));
                chk({tag, "_we_sel"}, 32'({WB_WE_OUT, WB_SEL_OUT}), 32'({v.we, v.sel}));
                if (v.we) begin
                    chk({tag, "_dat_wr"}, WB_DAT_WR_OUT, wr_pat(idx, acc));
                end
                if (!WB_STALL_IN) begin
                    p.rdy  = n + 1 + int'($urandom_range(v.max_lat, 0));
                    p.beat = acc;
                    p.a    = exp_adr;
                    q.push_back(p);
                    acc++;
                end
            end
            if (WR_VALID_IN && WR_READY_OUT) begin
                sent++;
            end
            if (drv_ack) begin
                void'(q.pop_front());
                last_ack_n = n;
            end
            if (drv_err) begin
                aborted = 1'b1;
                q.delete();
            end
            @(negedge CLK);
            n++;
        end
        idle_inputs();
        chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        chk({tag, "_err"}, 32'(err_seen), 32'(v.exp_err));
        if (v.we) begin
            chk({tag, "_wr_beats"}, 32'(acc), 32'(v.exp_beats));
            chk({tag, "_wr_words"}, 32'(sent), 32'(v.exp_beats));
        end else begin
            chk({tag, "_rd_beats"}, 32'(rd_cnt), 32'(v.exp_beats));
        end
        if (!v.exp_err) begin
            chk({tag, "_done_latency"}, 32'(done_n), 32'(last_ack_n + 1));
        end
    endtask

    initial begin
        int cyc_cnt;
        int done_cnt;
        bit err_v;

        RST_ASYNC  = 1'b1;
        CMD_WE_IN  = 1'b0;
        CMD_ADR_IN = '0;
        CMD_SEL_IN = '0;
        CMD_LEN_IN = '0;
        WR_DAT_IN  = '0;
        idle_inputs();

        //           we    adr            len sel  stall lat gap err  xerr beats
        vecs[0] = '{1'b0, 32'h0000_0100,  3, 4'hF,  0, 0, 1'b0, -1, 1'b0,  4};
        vecs[1] = '{1'b1, 32'h1FC0_0000,  0, 4'hF,  0, 0, 1'b0, -1, 1'b0,  1};
        vecs[2] = '{1'b0, 32'h0000_4000, 15, 4'hF, 30, 4, 1'b0, -1, 1'b0, 16};
        vecs[3] = '{1'b1, 32'h0000_8000,  7, 4'hF,  0, 1, 1'b1, -1, 1'b0,  8};
        vecs[4] = '{1'b0, 32'h0000_0200,  7, 4'hF,  0, 0, 1'b0,  2, 1'b1,  2};
        vecs[5] = '{1'b0, 32'hFFFF_FFF8,  3, 4'h3, 20, 2, 1'b0, -1, 1'b0,  4};
        vecs[6] = '{1'b1, 32'h0000_3000,  3, 4'hC, 50, 3, 1'b0, -1, 1'b0,  4};
        vecs[7] = '{1'b0, 32'h0000_0500,  0, 4'h1,  0, 2, 1'b0, -1, 1'b0,  1};

        repeat (2) @(negedge CLK);
        chk("rst_cyc_stb_we", 32'({WB_CYC_OUT, WB_STB_OUT, WB_WE_OUT}), 32'd0);
        chk("rst_status", 32'({RD_VALID_OUT, DONE_OUT, ERR_OUT, WR_READY_OUT}), 32'd0);
        chk("rst_cmd_ready", 32'(CMD_READY_OUT), 32'd0);
        chk("rst_adr", WB_ADR_OUT, 32'd0);
        chk("rst_sel_cti_bte", 32'({WB_SEL_OUT, WB_CTI_OUT, WB_BTE_OUT}), 32'd0);
        chk("rst_dat_wr", WB_DAT_WR_OUT, 32'd0);
        chk("rst_rd_dat", RD_DAT_OUT, 32'd0);
        RST_ASYNC = 1'b0;
        #1;
        chk("cmd_ready_after_rst", 32'(CMD_READY_OUT), 32'd1);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], i);
        end

        // Reset in the middle of a burst: the bus cycle drops without a clock edge
        // and no completion is reported.
        issue_cmd(1'b0, 32'h0000_0600, 7, 4'hF, "rstmid");
        repeat (3) @(negedge CLK);
        chk("rstmid_cyc_before", 32'(WB_CYC_OUT), 32'd1);
        #2;
        RST_ASYNC = 1'b1;
        #1;
        chk("rstmid_cyc_async", 32'({WB_CYC_OUT, WB_STB_OUT}), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            if (i == 2) begin
                RST_ASYNC = 1'b0;
            end
            #1;
            if (DONE_OUT) done_cnt++;
        end
        chk("rstmid_no_done", 32'(done_cnt), 32'd0);
        chk("rstmid_ready_after", 32'(CMD_READY_OUT), 32'd1);

        // Slave never acknowledges.
        issue_cmd(1'b0, 32'h0000_0700, 3, 4'hF, "noack");
        cyc_cnt  = 0;
        done_cnt = 0;
        err_v    = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (WB_CYC_OUT) cyc_cnt++;
            if (DONE_OUT) begin
                done_cnt++;
                err_v = ERR_OUT;
            end
            @(negedge CLK);
        end
`ifdef WB_BURST_MASTER_TIMEOUT_EN
        chk("noack_done", 32'(done_cnt), 32'd1);
        chk("noack_err", 32'(err_v), 32'd1);
        chk("noack_busy_cycles", 32'(cyc_cnt), 32'd16);
`else
        chk("noack_done", 32'(done_cnt), 32'd0);
        chk("noack_cyc_held", 32'(WB_CYC_OUT), 32'd1);
        chk("noack_busy_cycles", 32'(cyc_cnt), 32'd40);
`endif
        RST_ASYNC = 1'b1;
        @(negedge CLK);
        RST_ASYNC = 1'b0;
        @(negedge CLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_burst_master.md
WB_BURST_MASTER -- requirements
Module: wb_burst_master

Interface
REQ-001 Parameter MAX_LEN_P2, 4, log2 of max burst beats (LEN field width).
REQ-002 Parameter TIMEOUT_CYC, 255, ack watchdog limit in cycles (used only with WB_BURST_MASTER_TIMEOUT_EN).
REQ-003 CLK  in  1  single clock; all logic rising-edge.
REQ-004 RST_ASYNC  in  1  reset, asynchronous, active-high.
REQ-005 CMD_VALID_IN / CMD_READY_OUT  in/out  1/1  command handshake; transfer when both high.
REQ-006 CMD_ADR_IN  in  32  start byte address, word-aligned; CMD_WE_IN in 1 write/read; CMD_SEL_IN in 4 byte lanes, all beats; CMD_LEN_IN in MAX_LEN_P2 beats minus one.
REQ-007 WR_DAT_IN / WR_VALID_IN / WR_READY_OUT  in/in/out  32/1/1  write-data stream, one word per handshake.
REQ-008 RD_DAT_OUT / RD_VALID_OUT  out/out  32/1  read-data stream, no backpressure.
REQ-009 DONE_OUT / ERR_OUT  out/out  1/1  one-cycle completion pulse; ERR_OUT qualifies DONE_OUT.
REQ-010 WB_ADR_OUT 32, WB_CYC_OUT 1, WB_STB_OUT 1, WB_WE_OUT 1, WB_SEL_OUT 4, WB_CTI_OUT 3, WB_BTE_OUT 2, WB_DAT_WR_OUT 32  out  pipelined Wishbone B4 master.
REQ-011 WB_ACK_IN 1, WB_STALL_IN 1, WB_ERR_IN 1, WB_DAT_RD_IN 32  in  slave response.

Function
REQ-012 States IDLE, ISSUE, DRAIN, DONE; IDLE->ISSUE on command accept; ISSUE->DRAIN when final strobe accepted; DRAIN->DONE when ack count equals LEN+1; DONE->IDLE unconditionally after one cycle.
REQ-013 CMD_READY_OUT high only in IDLE; command fields registered on accept.
REQ-014 WB_CYC_OUT high throughout ISSUE and DRAIN; low in IDLE and DONE.
REQ-015 Strobe accepted when WB_STB_OUT high and WB_STALL_IN low; WB_ADR_OUT, WB_CTI_OUT, WB_DAT_WR_OUT held stable while stalled.
REQ-016 WB_ADR_OUT increments by 4 per accepted strobe; wraps modulo 2^32.
REQ-017 WB_CTI_OUT 3'b010 on every beat except last, 3'b111 on last beat (including LEN=0); WB_BTE_OUT constant 2'b00.
REQ-018 Reads: WB_STB_OUT asserted every ISSUE cycle; one strobe per cycle when unstalled.
REQ-019 Writes: one-word skid register; WR_READY_OUT high when register empty in ISSUE; WB_STB_OUT asserted only when register full; register freed on strobe accept (simultaneous refill allowed).
REQ-020 RD_VALID_OUT/RD_DAT_OUT registered from WB_ACK_IN/WB_DAT_RD_IN, 1-cycle latency, read bursts only, acks counted only while WB_CYC_OUT high.
REQ-021 Ack counter width MAX_LEN_P2+1; strobe and ack in same cycle both counted.
REQ-022 WB_ERR_IN in ISSUE or DRAIN: STB and CYC drop next cycle, go DONE with ERR_OUT=1; remaining beats abandoned, no further WR_READY_OUT.
REQ-023 DONE_OUT pulses exactly once per command, in DONE state.

Reset
REQ-024 RST_ASYNC high: state IDLE, all counters zero, skid register empty; WB_CYC_OUT, WB_STB_OUT, WB_WE_OUT, RD_VALID_OUT, DONE_OUT, ERR_OUT, WR_READY_OUT 0; CMD_READY_OUT 0 while reset high, 1 first cycle after release; WB_ADR_OUT, WB_SEL_OUT, WB_CTI_OUT, WB_BTE_OUT, data outputs 0.
REQ-025 Reset mid-burst: CYC drops immediately (asynchronous), no DONE_OUT generated.

Configuration
REQ-026 WB_BURST_MASTER_TIMEOUT_EN defined: counter reloads on every ack; TIMEOUT_CYC consecutive cycles in ISSUE/DRAIN without ack -> behaves as REQ-022 (DONE with ERR_OUT=1).
REQ-027 WB_BURST_MASTER_TIMEOUT_EN undefined: no watchdog logic; master waits indefinitely.

Structure
REQ-028 Shared package psx_wb_pkg: CTI constants (CLASSIC 3'b000, INCR 3'b010, EOB 3'b111), BTE_LINEAR 2'b00, state encoding.
REQ-029 One sub-module: wb_master_skid (one-word write skid register); all else flat.

Verification
REQ-030 Read LEN=3 at 0x0000_0100, zero latency -> ADR 0x100/104/108/10C, CTI 010,010,010,111, four RD_VALID_OUT, one DONE_OUT, ERR_OUT=0.
REQ-031 Write LEN=0 at 0x1FC0_0000 -> single strobe CTI 111, WE=1, DAT_WR equals WR_DAT_IN, DONE_OUT 1 cycle after ack.
REQ-032 Read LEN=15 with random STALL and ack latency 0-4 -> addresses/CTI stable across stalls, 16 data in order, exactly 16 acks counted.
REQ-033 Write LEN=7 with WR_VALID_IN gapped every other cycle -> STB only with valid data, 8 beats, correct data order.
REQ-034 WB_ERR_IN on beat 2 of LEN=7 read -> CYC low next cycle, DONE_OUT with ERR_OUT=1, 2 RD_VALID_OUT only.
REQ-035 TIMEOUT_EN, slave never acks, TIMEOUT_CYC=16 -> DONE_OUT with ERR_OUT=1 after 16 ackless cycles; without macro, CYC remains high.
